fifo_rd_packer: RTL and testbench
=================================

# fifo_rd_packer

Read-side consumer for the Async_FIFO, clocked entirely in the FIFO read domain. Pops DATA_WIDTH-bit entries from the FIFO read port and packs PACK consecutive entries into one wide word presented on a valid/ready master interface. A flush request emits a partially filled word with a lane-keep mask, so trailing data never sticks in the accumulator.

## Interface
- DATA_WIDTH, 8, width of one FIFO entry; matches the FIFO data width.
- PACK, 4, entries per output word; legal range 2..16.
- rclk  in  1  read-domain clock; all state on rising edge.
- rrst_n  in  1  reset, asynchronous assert, active-low.
- fifo_empty  in  1  FIFO empty flag, synchronous to rclk.
- fifo_data  in  DATA_WIDTH  FIFO data_out; valid in the cycle after a cycle with fifo_r_en=1.
- fifo_r_en  out  1  FIFO read enable; one entry popped per cycle high.
- flush  in  1  single-cycle pulse requesting emission of a partial word.
- m_valid  out  1  packed word valid.
- m_ready  in  1  downstream accepts when m_valid && m_ready.
- m_data  out  DATA_WIDTH*PACK  packed word; entry k in lanes [k*DATA_WIDTH +: DATA_WIDTH], first-popped entry in lane 0.
- m_keep  out  PACK  bit k set = lane k holds valid data.

## Operation
- State: FILL, DRAIN, OUT. Counters: cnt (0..PACK, entries captured), inflight (1 bit, read issued but not yet captured), flush_pend (1 bit).
- fifo_r_en = (state==FILL) && !fifo_empty && !flush_pend && (cnt + inflight < PACK), OR the accept-cycle case below. Combinational from registered state and fifo_empty; never high while fifo_empty=1.
- Capture: if inflight=1, fifo_data is written to lane cnt and cnt increments; inflight <= fifo_r_en.
- FILL -> OUT when a capture makes cnt==PACK; m_keep <= all ones.
- flush pulse sets flush_pend (ignored if cnt==0 and inflight==0 and not in OUT). In OUT, flush_pend stays set and is served after acceptance.
- FILL with flush_pend: if inflight=1 -> DRAIN; else if cnt>0 -> OUT with m_keep = (1<<cnt)-1; clear flush_pend on entry to OUT.
- DRAIN: wait for in-flight capture, then -> OUT with partial keep. No new reads in DRAIN.
- OUT: m_data/m_keep held stable while m_valid && !m_ready. Unused lanes drive zero. On accept: cnt<=0, lanes cleared, -> FILL; fifo_r_en may assert in the accept cycle if !fifo_empty and !flush_pend.
- cnt uses $clog2(PACK+1) bits; cnt+inflight compared without overflow.

## Timing
- Reset values: fifo_r_en=0, m_valid=0, m_data=0, m_keep=0, cnt=0, inflight=0, flush_pend=0, state=FILL.
- Read latency: fifo_r_en in cycle t -> entry captured at end of cycle t+1.
- Full word: reads in cycles 0..PACK-1 -> m_valid high in cycle PACK+1.
- Sustained throughput with fifo never empty and m_ready=1: one word per PACK+1 cycles.
- m_valid, once high, stays high until accepted; no data change while waiting (AXI-style).
- FIFO going empty mid-word: reads pause, partial accumulator retained indefinitely until more data or flush.
- flush and last capture in same cycle: full word takes priority (keep all ones); flush_pend then dropped because cnt==0 after accept.
- Reset mid-operation: accumulator and in-flight entry discarded (FIFO already popped it); outputs return to reset values asynchronously.

## Structure
- Package fifo_rd_pkg: state enum (FILL, DRAIN, OUT), default DATA_WIDTH/PACK localparams, keep-mask helper function (cnt -> mask).
- One sub-module natural: pack_lane_accum (lane register array, write-by-index, synchronous clear); FSM and handshake stay in the top.

## Test plan
- Reset then FIFO preloaded with 1..8, m_ready=1 -> two words 0x04030201 and 0x08070605, m_keep=4'hF, first m_valid 5 cycles after first fifo_r_en.
- Same data, m_ready=0 for 10 cycles after first m_valid -> m_data held at 0x04030201, fifo_r_en stays 0, no entries lost after release.
- FIFO holds 1,2,3 then flush pulse -> m_data=0x00030201, m_keep=4'b0111; next word starts empty.
- Flush pulsed in the cycle fifo_r_en pops the 2nd entry (0xAA,0xBB) -> DRAIN, then m_data=0x0000BBAA, m_keep=4'b0011.
- Flush with cnt=0, FIFO empty -> no m_valid, state remains FILL.
- rrst_n low while cnt=2 -> all outputs zero immediately; after release, new entries 5,6,7,8 give 0x08070605 with no stale lanes.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_rd_pkg;

  // Packer control states.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } rd_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PACK       = 4;
  localparam int unsigned MAX_PACK       = 16;

  // Lane-keep mask with the lowest n bits set; callers cast down to PACK bits.
  function automatic logic [MAX_PACK-1:0] keep_mask(input int unsigned n);
    logic [MAX_PACK-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_PACK; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_accum.sv
// Lane register array: one DATA_WIDTH lane per packed entry, written by index,
// cleared as a whole when the packed word is accepted downstream.
module pack_lane_accum
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PACK       = DEF_PACK,
  localparam int unsigned IW        = $clog2(PACK)
) (
  input  logic                       rclk,
  input  logic                       rrst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [IW-1:0]              wr_idx,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic [DATA_WIDTH*PACK-1:0] lanes_flat
);

  logic [DATA_WIDTH-1:0] lanes_q [PACK];
  logic [DATA_WIDTH-1:0] lanes_d [PACK];

  // Next lane contents: clear has priority over a write.
  always_comb begin
    // NOTE: the whole array gets a default before any conditional update, so no latch is inferred.
    lanes_d = lanes_q;
    for (int i = 0; i < PACK; i++) begin
      if (clr) begin
        lanes_d[i] = '0;
      end else if (wr_en && (wr_idx == IW'(i))) begin
        lanes_d[i] = wr_data;
      end
    end
  end

  // Lane storage.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      // NOTE: this array is reset (it is only PACK small registers) so a reset mid-word can never leak stale lanes.
      for (int i = 0; i < PACK; i++) lanes_q[i] <= '0;
    end else begin
      // NOTE: state is always updated with non-blocking assignments so every flop samples pre-edge values.
      lanes_q <= lanes_d;
    end
  end

  // Flatten lanes, entry k at bits [k*DATA_WIDTH +: DATA_WIDTH].
  always_comb begin
    lanes_flat = '0;
    for (int i = 0; i < PACK; i++) begin
      lanes_flat[i*DATA_WIDTH +: DATA_WIDTH] = lanes_q[i];
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain consumer of the async FIFO: pops entries and packs PACK of them
// into one wide word on a valid/ready master port. A flush pulse emits a
// partial word with a lane-keep mask so trailing data never stalls.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PACK       = DEF_PACK
) (
  input  logic                       rclk,
  input  logic                       rrst_n,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  output logic                       fifo_r_en,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH*PACK-1:0] m_data,
  output logic [PACK-1:0]            m_keep
);

  localparam int unsigned CW = $clog2(PACK + 1);
  localparam int unsigned IW = $clog2(PACK);

  rd_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            inflight_q, inflight_d;
  logic            flush_pend_q, flush_pend_d;
  logic [PACK-1:0] keep_q, keep_d;

  logic            accept;
  logic            rd_fill;
  logic            rd_accept;
  logic            lane_clr;
  logic [CW:0]     occupancy;
  logic [DATA_WIDTH*PACK-1:0] lanes_flat;

  // FIFO read enable from registered state; reset forces it low immediately.
  always_comb begin
    occupancy = {1'b0, cnt_q} + (CW+1)'(inflight_q);
    accept    = (state_q == OUT) && m_ready;
    rd_fill   = (state_q == FILL) && !fifo_empty && !flush_pend_q &&
                (occupancy < (CW+1)'(PACK));
    rd_accept = accept && !fifo_empty && !flush_pend_q;
    fifo_r_en = rrst_n && (rd_fill || rd_accept);
  end

  // Next-state, capture counting, flush bookkeeping and keep-mask selection.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    keep_d       = keep_q;
    flush_pend_d = flush_pend_q;
    inflight_d   = fifo_r_en;
    lane_clr     = 1'b0;

    // Data returned from last cycle's read lands in lane cnt.
    if (inflight_q) cnt_d = cnt_q + CW'(1);

    unique case (state_q)
      FILL: begin
        if (inflight_q && (cnt_d == CW'(PACK))) begin
          // A completed word wins over any pending flush.
          state_d = OUT;
          keep_d  = '1;
        end else if (flush_pend_q) begin
          if (inflight_q) begin
            state_d = DRAIN;
          end else begin
            if (cnt_q != '0) begin
              state_d = OUT;
              keep_d  = PACK'(keep_mask(32'(cnt_q)));
            end
            // Either served now or nothing to emit: drop the request.
            flush_pend_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        // Stay until the last in-flight entry has been captured.
        if (!inflight_q) begin
          state_d      = OUT;
          keep_d       = PACK'(keep_mask(32'(cnt_q)));
          flush_pend_d = 1'b0;
        end
      end
      OUT: begin
        if (accept) begin
          state_d  = FILL;
          cnt_d    = '0;
          keep_d   = '0;
          lane_clr = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase

    // A flush with nothing buffered outside OUT has no effect; otherwise it is
    // remembered (in OUT it is served, i.e. dropped, after acceptance).
    if (flush && !((cnt_q == '0) && !inflight_q && (state_q != OUT))) begin
      flush_pend_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      keep_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inflight_q   <= inflight_d;
      flush_pend_q <= flush_pend_d;
      keep_q       <= keep_d;
    end
  end

  pack_lane_accum #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK       (PACK)
  ) u_accum (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .clr        (lane_clr),
    .wr_en      (inflight_q),
    .wr_idx     (IW'(cnt_q)),
    .wr_data    (fifo_data),
    .lanes_flat (lanes_flat)
  );

  // Master port: data shown only while a word is offered, otherwise zero.
  always_comb begin
    m_valid = (state_q == OUT);
    m_keep  = keep_q;
    m_data  = m_valid ? lanes_flat : '0;
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a queue-based FIFO and packing model
// predict each emitted word; a monitor compares on every accepted handshake.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PK = 4;

  typedef struct packed {
    logic [DW*PK-1:0] data;
    logic [PK-1:0]    keep;
  } word_t;

  logic             rclk = 1'b0;
  logic             rrst_n = 1'b0;
  logic             fifo_empty;
  logic [DW-1:0]    fifo_data = '0;
  logic             fifo_r_en;
  logic             flush = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DW*PK-1:0] m_data;
  logic [PK-1:0]    m_keep;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] acc [$];
  word_t         exp_q [$];
  int            fifo_level = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  logic          ren_s = 1'b0;
  logic          flush_s = 1'b0;
  logic [DW-1:0] pop_v;
  logic          hold_prev = 1'b0;
  word_t         held;

  assign fifo_empty = (fifo_level == 0);

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep)
  );

  always #5 rclk = ~rclk;
  always @(posedge rclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: every PK popped entries form a full word; a flush emits
  // whatever has been popped since the last emitted word.
  task automatic emit_acc();
    word_t w;
    w = '0;
    for (int k = 0; k < acc.size(); k++) begin
      w.data[k*DW +: DW] = acc[k];
      w.keep[k] = 1'b1;
    end
    exp_q.push_back(w);
    acc.delete();
  endtask

  always @(negedge rclk) begin
    ren_s   = fifo_r_en;
    flush_s = flush;
  end

  // FIFO model (registered data_out) plus packing prediction.
  always @(posedge rclk) begin
    if (rrst_n) begin
      if (ren_s && fifo_q.size() > 0) begin
        pop_v = fifo_q.pop_front();
        fifo_level = fifo_q.size();
        fifo_data <= pop_v;
        acc.push_back(pop_v);
        if (acc.size() == PK) emit_acc();
      end
      if (flush_s && acc.size() > 0) emit_acc();
    end
  end

  // Monitor: FIFO protocol, hold-while-stalled and scoreboard compare.
  always @(negedge rclk) begin
    if (!rrst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (fifo_r_en) check("rd_en_while_empty", 64'(fifo_empty), 64'd0);
      if (hold_prev) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(m_data), 64'(held.data));
        check("hold_keep", 64'(m_keep), 64'(held.keep));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(exp_q.size()), 64'd1);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          check("word_data", 64'(m_data), 64'(e.data));
          check("word_keep", 64'(m_keep), 64'(e.keep));
        end
      end
      hold_prev = m_valid && !m_ready;
      held = '{data: m_data, keep: m_keep};
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    fifo_level = fifo_q.size();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_level != 0 || m_valid) && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!m_valid && n < budget) begin
      @(negedge rclk);
      n++;
    end
    check(name, 64'(m_valid), 64'd1);
  endtask

  initial begin
    int t0;
    int n;
    logic quiet;

    // Reset values.
    #1;
    check("reset_valid", 64'(m_valid), 64'd0);
    check("reset_data", 64'(m_data), 64'd0);
    check("reset_keep", 64'(m_keep), 64'd0);
    check("reset_ren", 64'(fifo_r_en), 64'd0);
    repeat (2) tick();
    rrst_n = 1'b1;
    tick();

    // Two full words back to back, latency and throughput.
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    n = 0;
    while (!fifo_r_en && n < 20) begin
      @(negedge rclk);
      n++;
    end
    t0 = cyc;
    wait_valid("first_valid_seen", 20);
    check("first_valid_latency", 64'(cyc - t0), 64'd5);
    @(negedge rclk);
    wait_valid("second_valid_seen", 20);
    check("second_valid_cycle", 64'(cyc - t0), 64'd10);
    drain("drain_full_words", 50);

    // Backpressure: word held, no reads while stalled, nothing lost.
    tick();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    wait_valid("stall_valid_seen", 20);
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      check("stall_data", 64'(m_data), 64'h04030201);
      check("stall_no_read", 64'(fifo_r_en), 64'd0);
    end
    tick();
    m_ready = 1'b1;
    drain("drain_after_stall", 60);

    // Partial word via flush, retained until flushed; next word starts empty.
    push(8'd1); push(8'd2); push(8'd3);
    repeat (6) tick();
    check("partial_retained", 64'(m_valid), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain("drain_partial", 30);
    for (int i = 4; i <= 7; i++) push(DW'(i));
    drain("drain_after_partial", 30);

    // Flush coinciding with the second pop: DRAIN path.
    tick();
    push(8'hAA); push(8'hBB);
    tick();
    check("flush_on_2nd_pop", 64'(fifo_r_en), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain("drain_flush_inflight", 30);

    // Flush with nothing buffered: no output, still accepting data.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_valid) quiet = 1'b0;
    end
    check("empty_flush_quiet", 64'(quiet), 64'd1);
    for (int i = 9; i <= 12; i++) push(DW'(i));
    drain("drain_after_empty_flush", 30);

    // Asynchronous reset with two entries buffered.
    push(8'd1); push(8'd2);
    repeat (5) tick();
    #2;
    rrst_n = 1'b0;
    acc.delete();
    exp_q.delete();
    #1;
    check("rst_mid_valid", 64'(m_valid), 64'd0);
    check("rst_mid_data", 64'(m_data), 64'd0);
    check("rst_mid_keep", 64'(m_keep), 64'd0);
    check("rst_mid_ren", 64'(fifo_r_en), 64'd0);
    repeat (2) tick();
    rrst_n = 1'b1;
    for (int i = 5; i <= 8; i++) push(DW'(i));
    drain("drain_after_reset", 30);

    // Randomized traffic, backpressure and flushes.
    for (int i = 0; i < 600; i++) begin
      tick();
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 6) push(DW'($urandom));
      #1;
      flush = !fifo_r_en && ($urandom_range(0, 15) == 0);
    end
    tick();
    flush = 1'b0;
    m_ready = 1'b1;
    n = 0;
    while (fifo_level != 0 && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain("drain_random", 300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
